if_pc_bht: RTL and testbench

- Fetch-stage PC generator with an integrated branch history table (BHT) of 2-bit saturating counters.
- Produces the instruction address for instruction memory.
- Gives the ID stage a taken/not-taken prediction; that prediction travels down the pipe as jmp_from_id.
- Applies redirects from ID (predicted-taken branch, JAL) and from EX (mispredict flush with new_inst_addr).
- Trains the BHT from EX branch resolution (we/jmp).

---
 rtl/if_pc_bht_pkg.sv | 16 +
 rtl/if_pc_bht_bht_2bit.sv | 43 ++++
 rtl/if_pc_bht.sv | 76 +++++++
 tb/tb_if_pc_bht.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pc_bht_pkg.sv
// Shared constants and types for the fetch-stage PC generator and its
// branch history table.
package if_pc_bht_pkg;

    localparam int unsigned INST_W = 32;
    localparam logic [INST_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    // 2-bit saturating counter states; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_t;

endpackage

// File: rtl/if_pc_bht_bht_2bit.sv
// Untagged table of 2-bit saturating counters: one combinational lookup,
// one synchronous update port, asynchronous reset to CNT_INIT.
module bht_2bit
    import if_pc_bht_pkg::*;
#(
    parameter int unsigned BHT_IDX_W = 6,
    parameter cnt_t        CNT_INIT  = WNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BHT_IDX_W-1:0] rd_idx,
    output logic                 rd_taken,
    input  logic                 upd_en,
    input  logic [BHT_IDX_W-1:0] upd_idx,
    input  logic                 upd_taken
);

    localparam int unsigned DEPTH = 1 << BHT_IDX_W;

    cnt_t tbl [DEPTH];

    // Lookup sees the pre-update value when read and write collide.
    assign rd_taken = tbl[rd_idx][1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl[i] <= CNT_INIT;
            end
        end else if (upd_en) begin
            if (upd_taken) begin
                if (tbl[upd_idx] != ST) begin
                    tbl[upd_idx] <= cnt_t'(tbl[upd_idx] + 2'd1);
                end
            end else begin
                if (tbl[upd_idx] != SNT) begin
                    tbl[upd_idx] <= cnt_t'(tbl[upd_idx] - 2'd1);
                end
            end
        end
    end

endmodule

// File: rtl/if_pc_bht.sv
// Fetch-stage PC generator with ID/EX redirects and an optional 2-bit BHT.
// Define BHT_EN to include the predictor; otherwise prediction is static not-taken.
module if_pc_bht
    import if_pc_bht_pkg::*;
#(
    parameter logic [INST_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter int unsigned       BHT_IDX_W = 6,
    parameter logic [1:0]        CNT_INIT  = WNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    output logic [INST_W-1:0] inst_addr,
    output logic              if_kill,
    input  logic              id_valid,
    input  logic              id_is_branch,
    input  logic              id_is_jal,
    input  logic [INST_W-1:0] id_inst_addr,
    input  logic [INST_W-1:0] id_target,
    output logic              jmp_pred,
    input  logic              ex_we,
    input  logic              ex_jmp,
    input  logic [INST_W-1:0] ex_inst_addr,
    input  logic              ex_flush,
    input  logic [INST_W-1:0] ex_new_inst_addr
);

    logic id_redir;

`ifdef BHT_EN
    logic bht_taken;
    logic unused_addr_bits;

    bht_2bit #(
        .BHT_IDX_W (BHT_IDX_W),
        .CNT_INIT  (cnt_t'(CNT_INIT))
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (id_inst_addr[BHT_IDX_W+1:2]),
        .rd_taken  (bht_taken),
        .upd_en    (ex_we),
        .upd_idx   (ex_inst_addr[BHT_IDX_W+1:2]),
        .upd_taken (ex_jmp)
    );

    assign jmp_pred = id_valid & id_is_branch & bht_taken;

    assign unused_addr_bits = ^{id_inst_addr[INST_W-1:BHT_IDX_W+2], id_inst_addr[1:0],
                                ex_inst_addr[INST_W-1:BHT_IDX_W+2], ex_inst_addr[1:0]};
`else
    localparam int unsigned unused_idx_w    = BHT_IDX_W;
    localparam logic [1:0]  unused_cnt_init = CNT_INIT;
    logic unused_inputs;

    assign jmp_pred      = 1'b0;
    assign unused_inputs = ^{ex_we, ex_jmp, ex_inst_addr, id_inst_addr, id_is_branch};
`endif

    assign id_redir = id_valid & ~stall & (id_is_jal | jmp_pred);
    assign if_kill  = ex_flush | id_redir;

    // EX flush beats everything, including stall: the ID instruction is wrong-path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_addr <= RESET_PC;
        end else if (ex_flush) begin
            inst_addr <= ex_new_inst_addr;
        end else if (id_redir) begin
            inst_addr <= id_target;
        end else if (!stall) begin
            inst_addr <= inst_addr + 32'd4;
        end
    end

endmodule

// File: tb/tb_if_pc_bht.sv
// Self-checking bench for if_pc_bht: directed scenarios plus randomized
// traffic checked against a counter-array/PC reference model.
module tb_if_pc_bht;

`ifdef BHT_EN
    localparam bit BHT_ON = 1'b1;
`else
    localparam bit BHT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] inst_addr;
    logic        if_kill;
    logic        id_valid;
    logic        id_is_branch;
    logic        id_is_jal;
    logic [31:0] id_inst_addr;
    logic [31:0] id_target;
    logic        jmp_pred;
    logic        ex_we;
    logic        ex_jmp;
    logic [31:0] ex_inst_addr;
    logic        ex_flush;
    logic [31:0] ex_new_inst_addr;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] exp_pc;
    int          cnt [64];

    always #5 clk = ~clk;

    if_pc_bht #(
        .RESET_PC  (32'h0000_0000),
        .BHT_IDX_W (6),
        .CNT_INIT  (2'b01)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .inst_addr        (inst_addr),
        .if_kill          (if_kill),
        .id_valid         (id_valid),
        .id_is_branch     (id_is_branch),
        .id_is_jal        (id_is_jal),
        .id_inst_addr     (id_inst_addr),
        .id_target        (id_target),
        .jmp_pred         (jmp_pred),
        .ex_we            (ex_we),
        .ex_jmp           (ex_jmp),
        .ex_inst_addr     (ex_inst_addr),
        .ex_flush         (ex_flush),
        .ex_new_inst_addr (ex_new_inst_addr)
    );

    function automatic int tbl_idx(input logic [31:0] a);
        return int'((a / 4) % 64);
    endfunction

    function automatic logic model_pred();
        return BHT_ON && id_valid && id_is_branch && (cnt[tbl_idx(id_inst_addr)] >= 2);
    endfunction

    function automatic logic model_kill();
        return ex_flush || (id_valid && !stall && (id_is_jal || model_pred()));
    endfunction

    task automatic model_reset();
        exp_pc = 32'h0;
        for (int i = 0; i < 64; i++) cnt[i] = 1;
    endtask

    task automatic idle_inputs();
        stall = 0; id_valid = 0; id_is_branch = 0; id_is_jal = 0;
        id_inst_addr = 0; id_target = 0; ex_we = 0; ex_jmp = 0;
        ex_inst_addr = 0; ex_flush = 0; ex_new_inst_addr = 0;
    endtask

    // Advance one clock edge and step the model with the inputs in force.
    task automatic tick();
        logic        redir;
        logic [31:0] npc;
        int          k;
        @(posedge clk);
        redir = id_valid && !stall && (id_is_jal || model_pred());
        if (ex_flush)      npc = ex_new_inst_addr;
        else if (redir)    npc = id_target;
        else if (stall)    npc = exp_pc;
        else               npc = exp_pc + 32'd4;
        if (BHT_ON && ex_we) begin
            k = tbl_idx(ex_inst_addr);
            if (ex_jmp) cnt[k] = (cnt[k] == 3) ? 3 : cnt[k] + 1;
            else        cnt[k] = (cnt[k] == 0) ? 0 : cnt[k] - 1;
        end
        exp_pc = npc;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        id_valid = 1; id_is_branch = 1;
        model_reset();
        #1;
        n_cmp++;
        if (inst_addr !== 32'h0) begin
            n_bad++; $display("FAIL reset_pc: got %h want %h", inst_addr, 32'h0);
        end
        n_cmp++;
        if (jmp_pred !== 1'b0 || if_kill !== 1'b0) begin
            n_bad++; $display("FAIL reset_comb: got pred=%b kill=%b want 0/0", jmp_pred, if_kill);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (inst_addr !== 32'h0) begin
            n_bad++; $display("FAIL reset_hold: got %h want %h", inst_addr, 32'h0);
        end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (inst_addr !== 32'(i * 4) || if_kill !== 1'b0 || jmp_pred !== 1'b0) begin
                n_bad++;
                $display("FAIL free_run[%0d]: got pc=%h kill=%b pred=%b want pc=%h kill=0 pred=0",
                         i, inst_addr, if_kill, jmp_pred, 32'(i * 4));
            end
            tick();
        end
    endtask

    task automatic test_stall();
        n_cmp++;
        if (inst_addr !== 32'h10) begin
            n_bad++; $display("FAIL stall_start: got %h want %h", inst_addr, 32'h10);
        end
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (inst_addr !== 32'h10) begin
                n_bad++; $display("FAIL stall_hold[%0d]: got %h want %h", i, inst_addr, 32'h10);
            end
        end
        stall = 0;
        tick();
        n_cmp++;
        if (inst_addr !== 32'h14) begin
            n_bad++; $display("FAIL stall_release: got %h want %h", inst_addr, 32'h14);
        end
    endtask

    task automatic test_training();
        logic [31:0] want;
        ex_we = 1; ex_jmp = 1; ex_inst_addr = 32'h40;
        tick();
        tick();
        ex_we = 0;
        ex_flush = 1; ex_new_inst_addr = 32'h40;
        tick();
        ex_flush = 0;
        n_cmp++;
        if (inst_addr !== 32'h40) begin
            n_bad++; $display("FAIL train_flush_to_40: got %h want %h", inst_addr, 32'h40);
        end
        id_valid = 1; id_is_branch = 1; id_inst_addr = 32'h40; id_target = 32'h80;
        #1;
        n_cmp++;
        if (jmp_pred !== BHT_ON || if_kill !== BHT_ON) begin
            n_bad++; $display("FAIL train_pred_taken: got pred=%b kill=%b want %b/%b",
                              jmp_pred, if_kill, BHT_ON, BHT_ON);
        end
        tick();
        want = BHT_ON ? 32'h80 : 32'h44;
        n_cmp++;
        if (inst_addr !== want) begin
            n_bad++; $display("FAIL train_redirect: got %h want %h", inst_addr, want);
        end
        id_valid = 0; id_is_branch = 0;
        ex_we = 1; ex_jmp = 0; ex_inst_addr = 32'h40;
        repeat (3) tick();
        ex_we = 0;
        id_valid = 1; id_is_branch = 1; id_inst_addr = 32'h40;
        #1;
        n_cmp++;
        if (jmp_pred !== 1'b0 || if_kill !== 1'b0) begin
            n_bad++; $display("FAIL train_pred_cleared: got pred=%b kill=%b want 0/0", jmp_pred, if_kill);
        end
        tick();
        n_cmp++;
        if (inst_addr !== exp_pc) begin
            n_bad++; $display("FAIL train_no_redirect: got %h want %h", inst_addr, exp_pc);
        end
        idle_inputs();
    endtask

    task automatic test_flush_priority();
        ex_flush = 1; ex_new_inst_addr = 32'h200;
        id_valid = 1; id_is_jal = 1; id_target = 32'h100;
        #1;
        n_cmp++;
        if (if_kill !== 1'b1) begin
            n_bad++; $display("FAIL flush_kill: got %b want 1", if_kill);
        end
        tick();
        n_cmp++;
        if (inst_addr !== 32'h200) begin
            n_bad++; $display("FAIL flush_over_jal: got %h want %h", inst_addr, 32'h200);
        end
        ex_flush = 0;
        tick();
        n_cmp++;
        if (inst_addr !== 32'h100) begin
            n_bad++; $display("FAIL jal_redirect: got %h want %h", inst_addr, 32'h100);
        end
        stall = 1;
        #1;
        n_cmp++;
        if (if_kill !== 1'b0) begin
            n_bad++; $display("FAIL jal_stalled_kill: got %b want 0", if_kill);
        end
        tick();
        n_cmp++;
        if (inst_addr !== 32'h100) begin
            n_bad++; $display("FAIL jal_stalled_hold: got %h want %h", inst_addr, 32'h100);
        end
        idle_inputs();
    endtask

    task automatic test_flush_stall();
        stall = 1; ex_flush = 1; ex_new_inst_addr = 32'hFFFF_FFFC;
        tick();
        n_cmp++;
        if (inst_addr !== 32'hFFFF_FFFC) begin
            n_bad++; $display("FAIL flush_over_stall: got %h want %h", inst_addr, 32'hFFFF_FFFC);
        end
        idle_inputs();
        tick();
        n_cmp++;
        if (inst_addr !== 32'h0) begin
            n_bad++; $display("FAIL pc_wrap: got %h want %h", inst_addr, 32'h0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            stall        = ($urandom_range(0, 4) == 0);
            id_valid     = ($urandom_range(0, 9) < 6);
            id_is_branch = ($urandom_range(0, 1) == 1);
            id_is_jal    = !id_is_branch && ($urandom_range(0, 4) == 0);
            id_inst_addr = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 1) * 256);
            id_target    = $urandom & 32'hFFFF_FFFC;
            ex_we        = ($urandom_range(0, 9) < 5);
            ex_jmp       = ($urandom_range(0, 2) != 0);
            ex_inst_addr = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 1) * 256);
            ex_flush     = ($urandom_range(0, 9) == 0);
            ex_new_inst_addr = $urandom & 32'hFFFF_FFFC;
            #1;
            n_cmp++;
            if (jmp_pred !== model_pred() || if_kill !== model_kill()) begin
                n_bad++; $display("FAIL rand_comb[%0d]: got pred=%b kill=%b want %b/%b",
                                  c, jmp_pred, if_kill, model_pred(), model_kill());
            end
            tick();
            n_cmp++;
            if (inst_addr !== exp_pc) begin
                n_bad++; $display("FAIL rand_pc[%0d]: got %h want %h", c, inst_addr, exp_pc);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_redirect();
        // train index of 0x40 towards taken so the reset of counters is observable
        ex_we = 1; ex_jmp = 1; ex_inst_addr = 32'h40;
        repeat (3) tick();
        idle_inputs();
        ex_flush = 1; ex_new_inst_addr = 32'h500;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (inst_addr !== 32'h0) begin
            n_bad++; $display("FAIL async_reset: got %h want %h", inst_addr, 32'h0);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (inst_addr !== 32'h0) begin
            n_bad++; $display("FAIL reset_discards_flush: got %h want %h", inst_addr, 32'h0);
        end
        idle_inputs();
        rst = 1'b0;
        model_reset();
        id_valid = 1; id_is_branch = 1; id_inst_addr = 32'h40;
        #1;
        n_cmp++;
        if (jmp_pred !== 1'b0) begin
            n_bad++; $display("FAIL reset_counters: got pred=%b want 0", jmp_pred);
        end
        tick();
        n_cmp++;
        if (inst_addr !== 32'h4) begin
            n_bad++; $display("FAIL post_reset_pc: got %h want %h", inst_addr, 32'h4);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_training();
        test_flush_priority();
        test_flush_stall();
        test_random();
        test_reset_mid_redirect();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
